// File: rtl/blankport_stim_pkg.sv
// Shared definitions for the four-valued stimulus generator.
// Digit codes: each base-4 digit of the vector index selects one of the
// four logic values (0, 1, X, Z) driven onto a single operand bit.
// State encoding: the enumeration FSM used by blankport_stimgen.
package blankport_stim_pkg;

  localparam logic [1:0] DIG_0 = 2'd0;
  localparam logic [1:0] DIG_1 = 2'd1;
  localparam logic [1:0] DIG_X = 2'd2;
  localparam logic [1:0] DIG_Z = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/blankport_stim_counter.sv
// Base-4 vector index counter with digit-to-value decode.
// The index holds 2*SIZE base-4 digits (two bits each). Digit d drives
// bit d of the concatenation {in1, in2}, so the most significant digit
// lands on in1[SIZE-1] and the least significant on in2[0].
// Ports:
//   clk, rst  - clock, synchronous active-high reset (index -> 0)
//   clr       - synchronous clear of the index (start of a pass)
//   inc       - advance the index by one
//   idx       - current index, 4*SIZE bits
//   last      - index is all-ones (final vector of a pass)
//   in1, in2  - decoded four-valued operands
module blankport_stim_counter #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [4*SIZE-1:0] idx,
  output logic              last,
  output logic [SIZE-1:0]   in1,
  output logic [SIZE-1:0]   in2
);
  import blankport_stim_pkg::*;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = &idx;

  for (genvar d = 0; d < 2*SIZE; d++) begin : g_dec
    logic [1:0] dig;
    assign dig = idx[2*d +: 2];
    if (d < SIZE) begin : g_in2
      assign in2[d] = (dig == DIG_Z) ? 1'bz :
                      (dig == DIG_X) ? 1'bx :
                      (dig == DIG_1);
    end else begin : g_in1
      assign in1[d-SIZE] = (dig == DIG_Z) ? 1'bz :
                           (dig == DIG_X) ? 1'bx :
                           (dig == DIG_1);
    end
  end

endmodule

// File: rtl/blankport_stimgen.sv
// Exhaustive four-valued stimulus generator for spec/impl comparison.
// A pass walks every combination of 0/1/X/Z on the two operands, presents
// each vector with a valid/ready handshake, waits SETTLE cycles, then
// samples the external comparator result for one cycle (chk_strobe).
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin a pass (ignored while busy)
//   in1, in2      - four-valued stimulus operands, SIZE bits each
//   vec_valid     - stimulus presented (DRIVE state)
//   vec_ready     - consumer accepts the stimulus
//   res_mismatch  - comparator says outputs differ, sampled on chk_strobe
//   chk_strobe    - res_mismatch is sampled this cycle
//   fail_count    - saturating count of mismatching vectors
//   first_fail    - index of the first mismatching vector of the pass
//   busy, done    - pass in progress / pass complete
module blankport_stimgen #(
  parameter int SIZE   = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [SIZE-1:0]   in1,
  output logic [SIZE-1:0]   in2,
  output logic              vec_valid,
  input  logic              vec_ready,
  input  logic              res_mismatch,
  output logic              chk_strobe,
  output logic [15:0]       fail_count,
  output logic [4*SIZE-1:0] first_fail,
  output logic              busy,
  output logic              done
);
  import blankport_stim_pkg::*;

  // Settle counter is loaded with SETTLE-1 so SETTLE state lasts exactly
  // SETTLE cycles before CHECK.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t              state;
  logic [7:0]          settle_cnt;
  logic [4*SIZE-1:0]   idx;
  logic                last;
  logic                ctr_clr;
  logic                ctr_inc;

  // Counter clear/advance decoded from the current state so the index
  // moves on the same edge the FSM leaves IDLE/DONE or CHECK.
  assign ctr_clr = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign ctr_inc = (state == ST_CHECK) && !last;

  blankport_stim_counter #(
    .SIZE (SIZE)
  ) u_ctr (
    .clk  (clk),
    .rst  (reset),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .idx  (idx),
    .last (last),
    .in1  (in1),
    .in2  (in2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vec_valid  <= 1'b0;
      chk_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            vec_valid  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail_count <= '0;
            first_fail <= '0;
          end
        end
        ST_DRIVE: begin
          if (vec_ready) begin
            state      <= ST_SETTLE;
            vec_valid  <= 1'b0;
            settle_cnt <= SETTLE_LAST;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state      <= ST_CHECK;
            chk_strobe <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        ST_CHECK: begin
          chk_strobe <= 1'b0;
          if (res_mismatch) begin
            if (fail_count != 16'hFFFF) begin
              fail_count <= fail_count + 16'd1;
            end
            // A zero count means no mismatch has been seen yet this pass.
            if (fail_count == 16'd0) begin
              first_fail <= idx;
            end
          end
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ST_DRIVE;
            vec_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blankport_stimgen.sv
// Bench for blankport_stimgen (SIZE=3, SETTLE=2): full enumeration passes
// with a latency/vector scoreboard, a table of known index->operand
// vectors, a ready stall, a mid-pass start, a rerun and an abort by reset.
module tb_blankport_stimgen;

  localparam int SZ   = 3;
  localparam int ST   = 2;
  localparam int NVEC = 1 << (4*SZ);
  localparam int IW   = 4*SZ;
  localparam int VW   = 2*SZ;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  wire  [SZ-1:0] in1;
  wire  [SZ-1:0] in2;
  logic          vec_valid;
  logic          vec_ready;
  logic          res_mismatch;
  logic          chk_strobe;
  logic [15:0]   fail_count;
  logic [IW-1:0] first_fail;
  logic          busy;
  logic          done;

  blankport_stimgen #(
    .SIZE   (SZ),
    .SETTLE (ST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in1          (in1),
    .in2          (in2),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .res_mismatch (res_mismatch),
    .chk_strobe   (chk_strobe),
    .fail_count   (fail_count),
    .first_fail   (first_fail),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] dv;
    int            cyc;
  } sb_t;

  typedef struct {
    int    k;
    string s1;
    string s2;
  } vec_t;

  sb_t           sb[$];
  vec_t          tbl[11];
  logic [IW-1:0] obs[NVEC];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            four;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // dv holds one base-4 digit per operand bit, bit b of {in1,in2} <-> dv[2b+:2].
  // X/Z digits are checked only when the simulator keeps four-valued state.
  function automatic void chk_vec(input string name, input logic [VW-1:0] act, input logic [IW-1:0] dv);
    bit    ok = 1'b1;
    string es = "";
    for (int b = VW-1; b >= 0; b--) begin
      case (dv[2*b +: 2])
        2'd0: begin ok &= (act[b] === 1'b0); es = {es, "0"}; end
        2'd1: begin ok &= (act[b] === 1'b1); es = {es, "1"}; end
        2'd2: begin if (four) ok &= (act[b] === 1'bx); es = {es, "X"}; end
        default: begin if (four) ok &= (act[b] === 1'bz); es = {es, "Z"}; end
      endcase
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %b, expected %s (cycle %0d)", name, act, es, cyc);
    end
  endfunction

  function automatic logic [1:0] dig_of(input byte c);
    case (c)
      "0":     return 2'd0;
      "1":     return 2'd1;
      "X":     return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [IW-1:0] dv_of_str(input string s1, input string s2);
    logic [IW-1:0] r = '0;
    for (int i = 0; i < SZ; i++) begin
      r[2*(VW-1-i) +: 2] = dig_of(s1[i]);
      r[2*(SZ-1-i) +: 2] = dig_of(s2[i]);
    end
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_vec_valid"},  64'(vec_valid),  64'd0);
    chk({tag, "_chk_strobe"}, 64'(chk_strobe), 64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
    chk({tag, "_fail_count"}, 64'(fail_count), 64'd0);
    chk({tag, "_first_fail"}, 64'(first_fail), 64'd0);
    chk_vec({tag, "_in"}, {in1, in2}, '0);
  endtask

  // One pass: pulses start, then plays consumer and comparator.
  task automatic run_pass(input bit mm, input bit stall, input bit midstart,
                          input int abort_at, output int nstb);
    int  acc = 0;
    int  stall_cnt = 0;
    bit  fin = 1'b0;
    bit  aborted = 1'b0;
    bit  ms_done = 1'b0;
    sb_t e;
    nstb = 0;
    sb.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_done_clr", 64'(done), 64'd0);
    chk("start_fail_clr", 64'(fail_count), 64'd0);
    for (int g = 0; g < NVEC*(ST+2) + 200 && !fin; g++) begin
      start = 1'b0;
      if (chk_strobe) begin
        nstb++;
        if (sb.size() == 0) begin
          chk("strobe_unexpected", 64'(chk_strobe), 64'd0);
          res_mismatch = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("strobe_latency", 64'(cyc), 64'(e.cyc));
          chk_vec("strobe_vec", {in1, in2}, e.dv);
          res_mismatch = mm && (e.dv == IW'(5) || e.dv == IW'(9));
        end
      end else begin
        res_mismatch = 1'($urandom_range(0, 1));
      end
      if (abort_at >= 0 && !aborted && acc == abort_at + 1 && !vec_valid && !chk_strobe) begin
        chk_vec("abort_settle_vec", {in1, in2}, IW'(abort_at));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        if (done) begin
          fin = 1'b1;
          chk("done_queue_empty", 64'(sb.size()), 64'd0);
        end else begin
          chk("busy_in_pass", 64'(busy), 64'd1);
        end
        vec_ready = 1'b1;
        if (vec_valid) begin
          chk_vec("drive_vec", {in1, in2}, IW'(acc));
          if (stall && acc == 3 && stall_cnt < 10) begin
            vec_ready = 1'b0;
            stall_cnt++;
          end else begin
            obs[acc] = {in1, in2};
            sb.push_back('{IW'(acc), cyc + ST + 1});
            acc++;
          end
        end
        if (midstart && !ms_done && acc == 200) begin
          start   = 1'b1;
          ms_done = 1'b1;
        end
        if (!fin) tick();
      end
    end
    start = 1'b0;
    res_mismatch = 1'b0;
    if (!fin) chk("pass_timeout", 64'd0, 64'd1);
  endtask

  initial begin : main
    logic probe;
    int   n;
    probe = 1'bx;
    four  = (probe !== 1'b0) && (probe !== 1'b1);

    tbl[0]  = '{0,    "000", "000"};
    tbl[1]  = '{1,    "000", "001"};
    tbl[2]  = '{2,    "000", "00X"};
    tbl[3]  = '{3,    "000", "00Z"};
    tbl[4]  = '{4,    "000", "010"};
    tbl[5]  = '{5,    "000", "011"};
    tbl[6]  = '{16,   "000", "100"};
    tbl[7]  = '{63,   "000", "ZZZ"};
    tbl[8]  = '{64,   "001", "000"};
    tbl[9]  = '{2048, "X00", "000"};
    tbl[10] = '{4095, "ZZZ", "ZZZ"};

    reset = 1'b1;
    start = 1'b1;
    vec_ready = 1'b1;
    res_mismatch = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    start = 1'b0;
    res_mismatch = 1'b0;
    reset = 1'b0;
    tick();
    check_reset_state("idle");

    // Pass 1: mismatches at 5 and 9, ready stall at index 3, stray start.
    run_pass(1'b1, 1'b1, 1'b1, -1, n);
    chk("p1_strobes",    64'(n),          64'(NVEC));
    chk("p1_done",       64'(done),       64'd1);
    chk("p1_busy",       64'(busy),       64'd0);
    chk("p1_vec_valid",  64'(vec_valid),  64'd0);
    chk("p1_fail_count", 64'(fail_count), 64'd2);
    chk("p1_first_fail", 64'(first_fail), 64'd5);
    for (int i = 0; i < 11; i++) begin
      chk_vec($sformatf("table_k%0d", tbl[i].k), obs[tbl[i].k][VW-1:0],
              dv_of_str(tbl[i].s1, tbl[i].s2));
    end
    for (int i = 0; i < 4; i++) begin
      res_mismatch = 1'b1;
      tick();
    end
    res_mismatch = 1'b0;
    chk("done_hold",      64'(done),       64'd1);
    chk("done_no_strobe", 64'(chk_strobe), 64'd0);
    chk("done_fail_hold", 64'(fail_count), 64'd2);

    // Pass 2: rerun after done, no mismatches.
    run_pass(1'b0, 1'b0, 1'b0, -1, n);
    chk("p2_strobes",    64'(n),          64'(NVEC));
    chk("p2_done",       64'(done),       64'd1);
    chk("p2_fail_count", 64'(fail_count), 64'd0);
    chk("p2_first_fail", 64'(first_fail), 64'd0);
    chk_vec("p2_last_vec", {in1, in2}, IW'(NVEC-1));

    // Pass 3: reset in SETTLE at index 100, then restart from 0.
    run_pass(1'b0, 1'b0, 1'b0, 100, n);
    check_reset_state("abort");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_valid", 64'(vec_valid), 64'd1);
    chk("restart_busy",  64'(busy),      64'd1);
    chk_vec("restart_vec", {in1, in2}, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blankport_stimgen.md
BLANKPORT_STIMGEN -- requirements
Module: blankport_stimgen

Interface
REQ-001 SHALL have parameter SIZE, default 4, giving the digit count of each operand.
REQ-002 SHALL have parameter SETTLE, default 2, giving the idle cycles between vector acceptance and result sampling (1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a full enumeration pass.
REQ-006 SHALL have ports in1 and in2, output, SIZE bits each: the current four-valued stimulus operands.
REQ-007 SHALL have port vec_valid, output, 1 bit: the stimulus is presented.
REQ-008 SHALL have port vec_ready, input, 1 bit: the consumer accepts the stimulus.
REQ-009 SHALL have port res_mismatch, input, 1 bit: the external spec/impl comparator reports outputs differ (!== semantics).
REQ-010 SHALL have port chk_strobe, output, 1 bit: res_mismatch is sampled this cycle.
REQ-011 SHALL have port fail_count, output, 16 bits: number of mismatching vectors.
REQ-012 SHALL have port first_fail, output, 2*SIZE*2 bits: index of the first mismatching vector.
REQ-013 SHALL have ports busy and done, output, 1 bit each: pass in progress; pass complete.

Function
REQ-014 SHALL encode each stimulus digit d in 0..3 as the value 0, 1, X, Z respectively.
REQ-015 SHALL enumerate the vector index from 0 to 4^(2*SIZE)-1 as 2*SIZE base-4 digits; the most significant digit drives in1[SIZE-1], and the least significant digit drives in2[0].
REQ-016 SHALL implement the FSM IDLE -> DRIVE -> SETTLE -> CHECK -> (DRIVE | DONE); DONE -> DRIVE on start; IDLE/DONE hold otherwise.
REQ-017 SHALL, on start in IDLE or DONE, clear fail_count, first_fail and the index, deassert done, and enter DRIVE on the next cycle.
REQ-018 SHALL assert vec_valid only in DRIVE, holding in1/in2 stable until the cycle where vec_valid and vec_ready are both high.
REQ-019 SHALL enter SETTLE on acceptance and remain there exactly SETTLE cycles with in1/in2 unchanged.
REQ-020 SHALL, in CHECK (one cycle), assert chk_strobe, sample res_mismatch, and keep in1/in2 unchanged.
REQ-021 SHALL, on a sampled mismatch, increment fail_count, saturating at 16'hFFFF.
REQ-022 SHALL, on the first sampled mismatch of a pass only, load first_fail with the current index.
REQ-023 SHALL leave CHECK to DONE when the index is all-ones (no wrap), otherwise increment the index and return to DRIVE.
REQ-024 SHALL assert busy in DRIVE, SETTLE and CHECK, and done only in DONE.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL ignore res_mismatch outside CHECK.
REQ-027 SHALL have a per-vector latency from acceptance to chk_strobe of exactly SETTLE+1 cycles.

Reset
REQ-028 SHALL, on reset, enter IDLE and drive vec_valid=0, chk_strobe=0, busy=0, done=0, fail_count=0, first_fail=0, index=0 and in1/in2 all zero.
REQ-029 SHALL let reset override start and any in-flight handshake, abandoning the pass without completing the current CHECK.

Structure
REQ-030 SHALL take the digit-to-value encoding constants and the FSM state encoding from a shared package, blankport_stim_pkg.
REQ-031 SHALL implement the base-4 index counter and digit-to-value decode as one sub-module, blankport_stim_counter, with increment and clear inputs, an index output and a last flag.

Verification
REQ-032 Reset then start with vec_ready=1 SHALL give first vector in1=0000, in2=0000; index 1 SHALL give in2=0001, index 2 SHALL give in2=000X, and index 3 SHALL give in2=000Z.
REQ-033 A full pass with SETTLE=2, vec_ready=1 and res_mismatch=0 SHALL give 65536 chk_strobes, last vector ZZZZ/ZZZZ, done=1 and fail_count=0.
REQ-034 res_mismatch=1 only at the strobes for indices 5 and 9 SHALL give fail_count=2 and first_fail=5.
REQ-035 vec_ready held low for 10 cycles at index 3 SHALL keep vec_valid=1 and in2=000Z stable, with no chk_strobe until 3 cycles after acceptance.
REQ-036 Reset asserted in SETTLE at index 100 SHALL give IDLE with all outputs zero; a following start SHALL restart at index 0.
REQ-037 start pulsed mid-pass SHALL be ignored, and a second start after done SHALL clear fail_count and rerun the pass.
